// File: rtl/opti.sv
// opti: operand forwarding, ALU operand selection and branch comparison for
// the execute stage. Everything here is combinational; clk and rst are
// present only so the block drops into the pipeline port list unchanged.
module opti (
    input  logic        clk,
    input  logic        rst,
    input  logic        A1_sel,
    input  logic        B1_sel,
    input  logic        A2_sel,
    input  logic        B2_sel,
    input  logic        Brun,
    input  logic [31:0] reg_rs1,
    input  logic [31:0] reg_rs2,
    input  logic [31:0] alu,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] data_w,
    output logic        Breq,
    output logic        Brlt
);

    logic [31:0] fa;
    logic [31:0] fb;
    logic        unused_pipeline_ports;

    // clk and rst are deliberately not used by any logic in this block
    assign unused_pipeline_ports = clk ^ rst;

    // Forwarding muxes: pick the fed-back ALU result over the register file
    // when a hazard is flagged. An explicit if/else keeps an X on the
    // unselected leg from reaching the output.
    always_comb begin
        fa = reg_rs1;
        fb = reg_rs2;
        if (A1_sel) begin
            fa = alu;
        end
        if (B1_sel) begin
            fb = alu;
        end
    end

    // Operand muxes: PC replaces rs1 for jumps/auipc, the immediate replaces
    // rs2 for I/S-type ops; store data always takes the forwarded rs2
    always_comb begin
        reg1   = fa;
        reg2   = fb;
        data_w = fb;
        if (A2_sel) begin
            reg1 = pc;
        end
        if (B2_sel) begin
            reg2 = imm;
        end
    end

    // Branch comparator works on the forwarded values, never on pc/imm
    always_comb begin
        Breq = (fa == fb);
        Brlt = 1'b0;
        if (Brun) begin
            Brlt = (fa < fb);
        end else begin
            Brlt = ($signed(fa) < $signed(fb));
        end
    end

endmodule

// File: tb/tb_opti.sv
// tb_opti: directed vectors with hand-computed expected values for opti.
module tb_opti;

    logic        clk;
    logic        rst;
    logic        A1_sel;
    logic        B1_sel;
    logic        A2_sel;
    logic        B2_sel;
    logic        Brun;
    logic [31:0] reg_rs1;
    logic [31:0] reg_rs2;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] data_w;
    logic        Breq;
    logic        Brlt;

    int total_checks;
    int bad_checks;

    opti dut (
        .clk     (clk),
        .rst     (rst),
        .A1_sel  (A1_sel),
        .B1_sel  (B1_sel),
        .A2_sel  (A2_sel),
        .B2_sel  (B2_sel),
        .Brun    (Brun),
        .reg_rs1 (reg_rs1),
        .reg_rs2 (reg_rs2),
        .alu     (alu),
        .pc      (pc),
        .imm     (imm),
        .reg1    (reg1),
        .reg2    (reg2),
        .data_w  (data_w),
        .Breq    (Breq),
        .Brlt    (Brlt)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive every select and data input, then let the outputs settle 3 ns
    task automatic apply_stimulus(input logic a1, input logic b1, input logic a2,
                                  input logic b2, input logic brun,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] alu_v, input logic [31:0] pc_v,
                                  input logic [31:0] imm_v);
        A1_sel  = a1;
        B1_sel  = b1;
        A2_sel  = a2;
        B2_sel  = b2;
        Brun    = brun;
        reg_rs1 = rs1;
        reg_rs2 = rs2;
        alu     = alu_v;
        pc      = pc_v;
        imm     = imm_v;
        #3;
    endtask

    // Baseline scenario: all selects 0, signed compare of AAAAAAAA vs CCCCCCCC
    task automatic check_baseline(input string tag);
        check_output({tag, "_reg1"},   reg1,   32'hAAAAAAAA);
        check_output({tag, "_reg2"},   reg2,   32'hCCCCCCCC);
        check_output({tag, "_data_w"}, data_w, 32'hCCCCCCCC);
        check_output({tag, "_Breq"},   {31'd0, Breq}, 32'd0);
        check_output({tag, "_Brlt"},   {31'd0, Brlt}, 32'd1);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst = 1'b1;
        @(negedge clk);

        // Baseline applied while reset is asserted; reset must not matter
        apply_stimulus(0, 0, 0, 0, 0, 32'hAAAAAAAA, 32'hCCCCCCCC,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_baseline("rst_apply");
        @(posedge clk); #3;
        check_baseline("rst_cyc1");
        @(posedge clk); #3;
        check_baseline("rst_cyc2");
        rst = 1'b0;
        #3;
        check_baseline("rst_release");
        @(posedge clk); #3;
        check_baseline("post_rst");

        // Both forwards from alu
        @(negedge clk);
        apply_stimulus(1, 1, 0, 0, 0, 32'hAAAAAAAA, 32'hCCCCCCCC,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_output("fwd_reg1",   reg1,   32'hDDDDDDDD);
        check_output("fwd_reg2",   reg2,   32'hDDDDDDDD);
        check_output("fwd_data_w", data_w, 32'hDDDDDDDD);
        check_output("fwd_Breq",   {31'd0, Breq}, 32'd1);
        check_output("fwd_Brlt",   {31'd0, Brlt}, 32'd0);

        // All selects 1: pc/imm win on operands, alu still drives data_w and compare
        apply_stimulus(1, 1, 1, 1, 1, 32'hAAAAAAAA, 32'hCCCCCCCC,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_output("all1_reg1",   reg1,   32'hEEEEEEEE);
        check_output("all1_reg2",   reg2,   32'hFFFFFFFF);
        check_output("all1_data_w", data_w, 32'hDDDDDDDD);
        check_output("all1_Breq",   {31'd0, Breq}, 32'd1);
        check_output("all1_Brlt",   {31'd0, Brlt}, 32'd0);

        // -1 vs 1: signed less-than, unsigned not
        apply_stimulus(0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h00000001,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_output("neg_signed_Brlt", {31'd0, Brlt}, 32'd1);
        check_output("neg_signed_Breq", {31'd0, Breq}, 32'd0);
        Brun = 1'b1;
        #3;
        check_output("neg_unsigned_Brlt", {31'd0, Brlt}, 32'd0);
        check_output("neg_unsigned_Breq", {31'd0, Breq}, 32'd0);

        // 1 vs FFFFFFFF: unsigned less-than, signed not
        apply_stimulus(0, 0, 0, 0, 1, 32'h00000001, 32'hFFFFFFFF,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_output("pos_unsigned_Brlt", {31'd0, Brlt}, 32'd1);
        Brun = 1'b0;
        #3;
        check_output("pos_signed_Brlt", {31'd0, Brlt}, 32'd0);

        // Most negative value equal on both sides
        apply_stimulus(0, 0, 0, 0, 0, 32'h80000000, 32'h80000000,
                       32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF);
        check_output("min_signed_Breq", {31'd0, Breq}, 32'd1);
        check_output("min_signed_Brlt", {31'd0, Brlt}, 32'd0);
        Brun = 1'b1;
        #3;
        check_output("min_unsigned_Breq", {31'd0, Breq}, 32'd1);
        check_output("min_unsigned_Brlt", {31'd0, Brlt}, 32'd0);

        // Mixed: rs1 from regfile, rs2 forwarded, imm on operand B
        apply_stimulus(0, 1, 0, 1, 1, 32'h00000010, 32'h12345678,
                       32'h00000020, 32'h00001000, 32'h00000004);
        check_output("mix_reg1",   reg1,   32'h00000010);
        check_output("mix_reg2",   reg2,   32'h00000004);
        check_output("mix_data_w", data_w, 32'h00000020);
        check_output("mix_Brlt",   {31'd0, Brlt}, 32'd1);
        check_output("mix_Breq",   {31'd0, Breq}, 32'd0);

        // rs1 forwarded, pc on operand A; compare still uses forwarded rs1
        apply_stimulus(1, 0, 1, 0, 0, 32'h00000010, 32'h00000020,
                       32'h00000020, 32'h00001000, 32'h00000004);
        check_output("pcfwd_reg1", reg1, 32'h00001000);
        check_output("pcfwd_reg2", reg2, 32'h00000020);
        check_output("pcfwd_Breq", {31'd0, Breq}, 32'd1);

        // X on unselected inputs must not leak through
        apply_stimulus(0, 0, 0, 0, 0, 32'h00000005, 32'h00000007,
                       'x, 'x, 'x);
        check_output("xblk_reg1",   reg1,   32'h00000005);
        check_output("xblk_reg2",   reg2,   32'h00000007);
        check_output("xblk_data_w", data_w, 32'h00000007);
        check_output("xblk_Breq",   {31'd0, Breq}, 32'd0);
        check_output("xblk_Brlt",   {31'd0, Brlt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
